// File: rtl/jtcps_cen_pkg.sv
// Shared defaults and common 48 MHz-domain clock-enable ratios for jtcps_multicen.
package jtcps_cen_pkg;

  localparam int unsigned DEF_CH = 4;
  localparam int unsigned DEF_W  = 10;
  localparam int unsigned DEF_R  = 4;

  // 48 MHz -> 10 MHz
  localparam int unsigned CEN10_NUM = 5;
  localparam int unsigned CEN10_DEN = 24;
  // 48 MHz -> 12 MHz
  localparam int unsigned CEN12_NUM = 1;
  localparam int unsigned CEN12_DEN = 4;
  // 48 MHz -> 16 MHz
  localparam int unsigned CEN16_NUM = 1;
  localparam int unsigned CEN16_DEN = 3;
  // 48 MHz -> 8 MHz
  localparam int unsigned CEN8_NUM  = 1;
  localparam int unsigned CEN8_DEN  = 6;
  // 48 MHz -> 4 MHz
  localparam int unsigned CEN4_NUM  = 1;
  localparam int unsigned CEN4_DEN  = 12;

endpackage

// File: rtl/jtcps_cen_acc.sv
// One fractional clock-enable channel: main accumulator (cen), half-period
// shifted accumulator (cenb), optional replay counter for held pulses, ratio check.
module jtcps_cen_acc #(
  parameter int unsigned W       = 10,
  parameter int unsigned R       = 4,
  parameter int unsigned RECOVER = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         sync,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  input  logic         hold,
  output logic         cen,
  output logic         cenb,
  output logic         err
);

  localparam logic [R-1:0] PEND_MAX = '1;

  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] accb_q, accb_d;
  logic [R-1:0] pend_q, pend_d;
  logic         cen_q, cen_d;
  logic         cenb_q, cenb_d;
  logic         err_q, err_d;

  logic         invalid;
  logic         ovf, ovfb;
  logic [W-1:0] acc_nx, accb_nx;
  logic [W-1:0] half;

  // One accumulator step. An accumulator left >= den by a ratio change (or by a
  // period of invalid ratio) is cleared before adding, so the W+1-bit sum can
  // never wrap. Returns {overflow, next value}.
  function automatic logic [W:0] acc_step(input logic [W-1:0] a,
                                          input logic [W-1:0] n,
                                          input logic [W-1:0] d);
    logic [W-1:0] a_c;
    logic [W:0]   s;
    logic [W:0]   r;
    a_c = (a >= d) ? '0 : a;
    s   = {1'b0, a_c} + {1'b0, n};
    if (s >= {1'b0, d}) begin
      s = s - {1'b0, d};
      r = {1'b1, s[W-1:0]};
    end else begin
      r = {1'b0, s[W-1:0]};
    end
    return r;
  endfunction

  // Next-state computation for both accumulators, pending counter and outputs
  always_comb begin
    invalid = (den == '0) || (num > den);
    half    = den >> 1;
    {ovf, acc_nx}   = acc_step(acc_q, num, den);
    {ovfb, accb_nx} = acc_step(accb_q, num, den);

    acc_d  = acc_q;
    accb_d = accb_q;
    pend_d = pend_q;
    cen_d  = 1'b0;
    cenb_d = 1'b0;
    err_d  = invalid;

    if (sync) begin
      acc_d  = '0;
      accb_d = half;
      pend_d = '0;
    end else if (!invalid) begin
      acc_d  = acc_nx;
      accb_d = accb_nx;
      cenb_d = ovfb;
      if (hold) begin
        if (ovf && pend_q != PEND_MAX) pend_d = pend_q + R'(1);
      end else begin
        // Replayed pulses only use cycles without a fresh overflow, so cen
        // never carries more than one pulse per cycle.
        cen_d = ovf | (pend_q != '0);
        if (!ovf && pend_q != '0) pend_d = pend_q - R'(1);
      end
    end

    if (RECOVER == 0) pend_d = '0;
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q  <= '0;
      accb_q <= den >> 1;
      pend_q <= '0;
      cen_q  <= 1'b0;
      cenb_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      accb_q <= accb_d;
      pend_q <= pend_d;
      cen_q  <= cen_d;
      cenb_q <= cenb_d;
      err_q  <= err_d;
    end
  end

  assign cen  = cen_q;
  assign cenb = cenb_q;
  assign err  = err_q;

endmodule

// File: rtl/jtcps_multicen.sv
// Multi-channel fractional clock-enable generator: unpacks per-channel ratios
// and fans sync out to CH independent jtcps_cen_acc channels.
module jtcps_multicen
  import jtcps_cen_pkg::*;
#(
  parameter int unsigned CH      = DEF_CH,
  parameter int unsigned W       = DEF_W,
  parameter int unsigned RECOVER = 1,
  parameter int unsigned R       = DEF_R
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [CH*W-1:0] num,
  input  logic [CH*W-1:0] den,
  input  logic [CH-1:0]   hold,
  input  logic            sync,
  output logic [CH-1:0]   cen,
  output logic [CH-1:0]   cenb,
  output logic [CH-1:0]   err
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    jtcps_cen_acc #(
      .W       (W),
      .R       (R),
      .RECOVER (RECOVER)
    ) u_acc (
      .clk  (clk),
      .rstn (rstn),
      .sync (sync),
      .num  (num[i*W +: W]),
      .den  (den[i*W +: W]),
      .hold (hold[i]),
      .cen  (cen[i]),
      .cenb (cenb[i]),
      .err  (err[i])
    );
  end

endmodule

// File: tb/tb_jtcps_multicen.sv
// Directed bench for jtcps_multicen: ratio table plus hold/replay, invalid
// ratio, sync and reset corner sequences. A RECOVER=0 instance shares inputs.
module tb_jtcps_multicen;
  import jtcps_cen_pkg::*;

  localparam int CH = 4;
  localparam int W  = 10;
  localparam int R  = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic [CH*W-1:0] num, den;
  logic [CH-1:0]   hold;
  logic            sync;
  logic [CH-1:0]   cen, cenb, err;
  logic [CH-1:0]   cen_nr, cenb_nr, err_nr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jtcps_multicen #(.CH(CH), .W(W), .RECOVER(1), .R(R)) dut (
    .clk(clk), .rstn(rstn), .num(num), .den(den), .hold(hold), .sync(sync),
    .cen(cen), .cenb(cenb), .err(err)
  );

  jtcps_multicen #(.CH(CH), .W(W), .RECOVER(0), .R(R)) dut_nr (
    .clk(clk), .rstn(rstn), .num(num), .den(den), .hold(hold), .sync(sync),
    .cen(cen_nr), .cenb(cenb_nr), .err(err_nr)
  );

  typedef struct {
    int n;
    int d;
    int cycles;
    int exp_cen;
    int exp_cenb;
    int first_cen;
    int first_cenb;
    int min_gap;
    int max_gap;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input int n, input int d);
    num[ch*W +: W] = W'(n);
    den[ch*W +: W] = W'(d);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  initial begin
    int cnt, cntb, first, firstb, last, gmin, gmax;
    int fc[CH];
    int fcb[CH];

    tbl[0] = '{1, 4, 48, 12, 12, 4, 2, 4, 4};
    tbl[1] = '{5, 12, 1200, 500, 500, 3, 2, 2, 3};
    tbl[2] = '{CEN16_NUM, CEN16_DEN, 36, 12, 12, 3, 2, 3, 3};
    tbl[3] = '{CEN10_NUM, CEN10_DEN, 240, 50, 50, 5, 3, 4, 5};
    tbl[4] = '{4, 4, 20, 20, 20, 1, 1, 1, 1};
    tbl[5] = '{0, 7, 50, 0, 0, 0, 0, 0, 0};
    tbl[6] = '{1023, 1023, 10, 10, 10, 1, 1, 1, 1};
    tbl[7] = '{1, 1023, 1023, 1, 1, 1023, 512, 0, 0};

    rstn = 1'b0; hold = '0; sync = 1'b0; num = '0; den = '0;

    // ---- ratio table ----
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < CH; c++) set_ch(c, tbl[r].n, tbl[r].d);
      rstn = 1'b0;
      step();
      check($sformatf("rst_cen[%0d]", r), int'(cen), 0);
      check($sformatf("rst_cenb[%0d]", r), int'(cenb), 0);
      check($sformatf("rst_err[%0d]", r), int'(err | err_nr), 0);
      rstn = 1'b1;
      cnt = 0; cntb = 0; first = 0; firstb = 0; last = 0; gmin = 0; gmax = 0;
      for (int k = 1; k <= tbl[r].cycles; k++) begin
        step();
        if (cen[0]) begin
          if (first == 0) first = k;
          if (last != 0) begin
            if (gmin == 0 || k - last < gmin) gmin = k - last;
            if (k - last > gmax) gmax = k - last;
          end
          last = k;
          cnt++;
        end
        if (cenb[0]) begin
          if (firstb == 0) firstb = k;
          cntb++;
        end
      end
      check($sformatf("count_cen[%0d]", r), cnt, tbl[r].exp_cen);
      check($sformatf("count_cenb[%0d]", r), cntb, tbl[r].exp_cenb);
      check($sformatf("first_cen[%0d]", r), first, tbl[r].first_cen);
      check($sformatf("first_cenb[%0d]", r), firstb, tbl[r].first_cenb);
      check($sformatf("min_gap[%0d]", r), gmin, tbl[r].min_gap);
      check($sformatf("max_gap[%0d]", r), gmax, tbl[r].max_gap);
      check($sformatf("err_run[%0d]", r), int'(err), 0);
    end

    // ---- hold with replay (dut) and without (dut_nr), ratio 1/2 ----
    for (int c = 0; c < CH; c++) set_ch(c, 1, 2);
    do_reset();
    hold = 4'b0001;
    for (int k = 1; k <= 22; k++) begin
      step();
      check($sformatf("hold_cen_k%0d", k), int'(cen[0]),
            (k >= 11 && k <= 20) || k == 22 ? 1 : 0);
      check($sformatf("hold_cen_norec_k%0d", k), int'(cen_nr[0]),
            (k >= 11 && (k % 2) == 0) ? 1 : 0);
      if (k == 1) begin
        check("hold_cenb_free", int'(cenb[0]), 1);
        check("hold_cenb_free_norec", int'(cenb_nr[0]), 1);
      end
      if (k == 10) hold = '0;
    end

    // ---- invalid ratio, recovery, and clamp on ratio change ----
    for (int c = 0; c < CH; c++) set_ch(c, 1, 4);
    do_reset();
    step(); step();
    set_ch(0, 1, 0);
    set_ch(1, 5, 4);
    set_ch(2, 1, 2);
    for (int k = 3; k <= 8; k++) begin
      step();
      check($sformatf("inv_err_k%0d", k), int'(err), 3);
      check($sformatf("inv_cen_k%0d", k), int'(cen[1:0]), 0);
      check($sformatf("inv_cenb_k%0d", k), int'(cenb[1:0]), 0);
      if (k == 3) check("clamp_cen_k3", int'(cen[2]), 0);
      if (k == 4) check("clamp_cen_k4", int'(cen[2]), 1);
    end
    set_ch(0, 1, 3);
    set_ch(1, 1, 3);
    for (int k = 9; k <= 15; k++) begin
      step();
      check($sformatf("valid_err_k%0d", k), int'(err), 0);
      check($sformatf("valid_cen0_k%0d", k), int'(cen[0]), ((k - 9) % 3) == 0 ? 1 : 0);
      check($sformatf("valid_cen1_k%0d", k), int'(cen[1]), ((k - 9) % 3) == 0 ? 1 : 0);
    end

    // ---- sync mid-run on four different ratios ----
    set_ch(0, 1, 4);
    set_ch(1, 1, 3);
    set_ch(2, 5, 12);
    set_ch(3, 5, 24);
    do_reset();
    for (int k = 1; k <= 7; k++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_cen", int'(cen), 0);
    check("sync_cenb", int'(cenb), 0);
    for (int c = 0; c < CH; c++) begin fc[c] = 0; fcb[c] = 0; end
    for (int j = 1; j <= 8; j++) begin
      step();
      for (int c = 0; c < CH; c++) begin
        if (cen[c] && fc[c] == 0) fc[c] = j;
        if (cenb[c] && fcb[c] == 0) fcb[c] = j;
      end
    end
    check("sync_first_cen0", fc[0], 4);
    check("sync_first_cen1", fc[1], 3);
    check("sync_first_cen2", fc[2], 3);
    check("sync_first_cen3", fc[3], 5);
    check("sync_first_cenb0", fcb[0], 2);
    check("sync_first_cenb1", fcb[1], 2);
    check("sync_first_cenb2", fcb[2], 2);
    check("sync_first_cenb3", fcb[3], 3);

    // ---- reset while hold and pending are active ----
    for (int c = 0; c < CH; c++) set_ch(c, 1, 2);
    do_reset();
    hold = 4'b0001;
    set_ch(3, 1, 0);
    for (int k = 1; k <= 6; k++) step();
    check("pre_rst_err3", int'(err[3]), 1);
    rstn = 1'b0;
    step();
    check("hold_rst_cen", int'(cen), 0);
    check("hold_rst_cenb", int'(cenb), 0);
    check("hold_rst_err", int'(err), 0);
    rstn = 1'b1;
    hold = '0;
    set_ch(3, 1, 2);
    step();
    check("post_rst_cen_k1", int'(cen[0]), 0);
    step();
    check("post_rst_cen_k2", int'(cen[0]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
